// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder datapath.
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = 25;
  localparam int EXP_MAX = 255;

  // Bit positions inside the {overflow, underflow, inexact} flag vector.
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Classification of a raw sum before normalisation.
  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_CARRY = 2'd1,
    CLS_NORM  = 2'd2,
    CLS_UFLOW = 2'd3
  } fp_class_e;

  // Shared 25-bit logarithmic left shifter, zero-filled.
  function automatic logic [MANT_W-1:0] barrelLeft(input logic [MANT_W-1:0] x,
                                                   input logic [4:0]        sh);
    logic [MANT_W-1:0] v;
    v = x;
    if (sh[0]) v = v << 1;
    if (sh[1]) v = v << 2;
    if (sh[2]) v = v << 4;
    if (sh[3]) v = v << 8;
    if (sh[4]) v = v << 16;
    return v;
  endfunction

endpackage

// File: rtl/fp_add_normalize_round_lzc24.sv
// Combinational 24-bit leading-zero counter; all-zero input gives 24.
module lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  count
);

  // Scan upward so the most significant set bit has the final say.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize_round.sv
// Post-add normalise/round/pack stage of the FP32 adder, two pipeline stages.
//
// Handshake: a beat moves on in_valid & in_ready; a result moves on
// out_valid & out_ready. Both stages advance together when en = ~out_valid |
// out_ready, so in_ready = en and a stalled result holds every register.
module fp_add_normalize_round #(
  parameter int EXP_W  = fp_add_pkg::EXP_W,
  parameter int FRAC_W = fp_add_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_mant,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [2:0]        out_flags
);
  import fp_add_pkg::*;

  localparam int MW = FRAC_W + 2;

  logic              en;
  logic [4:0]        lz_in;
  fp_class_e         cls_in;

  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [MW-1:0]     s1_mant;
  logic [2:0]        s1_grs;
  fp_class_e         s1_cls;
  logic [4:0]        s1_lz;

  logic [MW-1:0]     shifted;
  logic [MW-1:0]     r_ins;
  logic [FRAC_W:0]   m;
  logic              g_bit, r_bit, s_bit;
  logic [EXP_W:0]    e;
  logic              round_up;
  logic [MW-1:0]     m_r;
  logic [EXP_W:0]    e_r;
  logic              inexact;
  logic [EXP_W-1:0]  nxt_exp;
  logic [FRAC_W-1:0] nxt_frac;
  logic [2:0]        nxt_flags;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  lzc24 u_lzc (
    .din   (in_mant[FRAC_W:0]),
    .count (lz_in)
  );

  // Classify the incoming sum; a zero mantissa with live guard bits cannot be normalised.
  always_comb begin
    cls_in = CLS_NORM;
    if (in_mant[MW-1])
      cls_in = CLS_CARRY;
    else if (in_mant == '0 && in_grs == 3'b000)
      cls_in = CLS_ZERO;
    else if (in_mant[FRAC_W:0] == '0 || in_exp <= EXP_W'(lz_in))
      cls_in = CLS_UFLOW;
  end

  // Stage 1 register: raw beat plus its class and leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_grs   <= '0;
      s1_cls   <= CLS_ZERO;
      s1_lz    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_mant <= in_mant;
        s1_grs  <= in_grs;
        s1_cls  <= cls_in;
        s1_lz   <= lz_in;
      end
    end
  end

  // Normalise, round to nearest-even and pack the result fields.
  always_comb begin
    // Left shift of {mant, g, r}: barrelLeft moves {mant, g}, r lands at lz-1.
    shifted = barrelLeft({s1_mant[FRAC_W:0], s1_grs[2]}, s1_lz);
    r_ins   = '0;
    if (s1_lz != 5'd0) r_ins = MW'(s1_grs[1]) << (s1_lz - 5'd1);
    shifted = shifted | r_ins;

    if (s1_cls == CLS_CARRY) begin
      m     = s1_mant[MW-1:1];
      g_bit = s1_mant[0];
      r_bit = s1_grs[2];
      s_bit = s1_grs[1] | s1_grs[0];
      e     = {1'b0, s1_exp} + (EXP_W+1)'(1);
    end else begin
      m     = shifted[MW-1:1];
      g_bit = shifted[0];
      r_bit = (s1_lz == 5'd0) ? s1_grs[1] : 1'b0;
      s_bit = s1_grs[0];
      e     = {1'b0, s1_exp} - (EXP_W+1)'(s1_lz);
    end

    round_up = g_bit & (r_bit | s_bit | m[0]);
    m_r      = {1'b0, m} + MW'(round_up);
    e_r      = e + (EXP_W+1)'(m_r[MW-1]);
    inexact  = g_bit | r_bit | s_bit;

    nxt_exp   = '0;
    nxt_frac  = '0;
    nxt_flags = '0;
    case (s1_cls)
      CLS_ZERO: ;
      CLS_UFLOW: begin
        nxt_flags[FLAG_UNF] = 1'b1;
        nxt_flags[FLAG_INX] = |s1_grs;
      end
      default: begin
        if (e_r >= (EXP_W+1)'(EXP_MAX)) begin
          nxt_exp             = EXP_W'(EXP_MAX);
          nxt_flags[FLAG_OVF] = 1'b1;
        end else begin
          nxt_exp  = e_r[EXP_W-1:0];
          nxt_frac = m_r[MW-1] ? m_r[FRAC_W:1] : m_r[FRAC_W-1:0];
        end
        nxt_flags[FLAG_INX] = inexact;
      end
    endcase
  end

  // Stage 2 register: packed result held until downstream accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign  <= s1_sign;
        out_exp   <= nxt_exp;
        out_frac  <= nxt_frac;
        out_flags <= nxt_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Bench for fp_add_normalize_round: literal pins, stall, reset and random traffic.
module tb_fp_add_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic [2:0]  in_grs = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [34:0] exp_q[$];
  bit rand_done;

  fp_add_normalize_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac), .out_flags(out_flags)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {sign, exp, frac, flags} from plain arithmetic on the sum.
  function automatic logic [34:0] model(input logic sg, input logic [7:0] ex,
                                        input logic [24:0] mt, input logic [2:0] grs);
    int e, lz, mi, dropped, half;
    logic [25:0] full;
    logic [23:0] x;
    bit inx;
    if (mt == 0 && grs == 0) return {sg, 8'd0, 23'd0, 3'b000};
    if (mt[24]) begin
      mi = int'(mt[24:1]);
      dropped = int'({mt[0], grs});   // 4 discarded bits, half = 8
      half = 8;
      e = int'(ex) + 1;
    end else begin
      x = mt[23:0];
      if (x == 0) return {sg, 8'd0, 23'd0, 2'b01, |grs};
      lz = 0;
      while (x[23] == 1'b0) begin x = x << 1; lz++; end
      if (int'(ex) <= lz) return {sg, 8'd0, 23'd0, 2'b01, |grs};
      full = {mt[23:0], grs[2:1]} << lz;
      mi = int'(full[25:2]);
      dropped = int'({full[1:0], grs[0]});  // 3 discarded bits, half = 4
      half = 4;
      e = int'(ex) - lz;
    end
    inx = (dropped != 0);
    if (dropped > half || (dropped == half && (mi % 2) == 1)) mi = mi + 1;
    if (mi == (1 << 24)) begin mi = mi >> 1; e = e + 1; end
    if (e >= 255) return {sg, 8'hFF, 23'd0, 2'b10, inx};
    return {sg, 8'(e), 23'(mi), 2'b00, inx};
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- scoreboard: one compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stream: unexpected result %0h", {out_sign, out_exp, out_frac, out_flags});
        end else begin
          chk("stream", 64'({out_sign, out_exp, out_frac, out_flags}), 64'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_mant, in_grs));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic drive_beat(input logic sg, input logic [7:0] ex,
                            input logic [24:0] mt, input logic [2:0] grs);
    bit acc;
    in_sign = sg; in_exp = ex; in_mant = mt; in_grs = grs; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk) acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("drive_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // One isolated beat with literal expectations and a latency check.
  task automatic run_literal(input string name, input logic sg, input logic [7:0] ex,
                             input logic [24:0] mt, input logic [2:0] grs,
                             input logic [7:0] w_exp, input logic [22:0] w_frac,
                             input logic [2:0] w_flags);
    @(posedge clk);
    #1;
    drive_beat(sg, ex, mt, grs);
    @(negedge clk);
    chk({name, "_lat1"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_sign"}, 64'(out_sign), 64'(sg));
    chk({name, "_exp"}, 64'(out_exp), 64'(w_exp));
    chk({name, "_frac"}, 64'(out_frac), 64'(w_frac));
    chk({name, "_flags"}, 64'(out_flags), 64'(w_flags));
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 300 && !empty; i++) begin
      @(negedge clk);
      empty = (exp_q.size() == 0) && !out_valid;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [34:0] held;
    int out_before;
    logic [24:0] mt;
    logic [7:0] ex;

    // reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'({out_sign, out_exp, out_frac, out_flags}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // hand-computed literal cases
    run_literal("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 8'd128, 23'd0, 3'b000);
    run_literal("cancel",       1'b1, 8'd130, 25'h0000001, 3'b000, 8'd107, 23'd0, 3'b000);
    run_literal("round_carry",  1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 8'd128, 23'd0, 3'b001);
    run_literal("tie_even",     1'b0, 8'd127, 25'h0800000, 3'b100, 8'd127, 23'd0, 3'b001);
    run_literal("tie_odd",      1'b0, 8'd127, 25'h0800001, 3'b100, 8'd127, 23'd2, 3'b001);
    run_literal("overflow",     1'b0, 8'd254, 25'h1000000, 3'b000, 8'd255, 23'd0, 3'b100);
    run_literal("underflow",    1'b1, 8'd5,   25'h0000100, 3'b000, 8'd0,   23'd0, 3'b010);
    run_literal("zero",         1'b1, 8'd90,  25'h0000000, 3'b000, 8'd0,   23'd0, 3'b000);
    run_literal("grs_only",     1'b0, 8'd100, 25'h0000000, 3'b011, 8'd0,   23'd0, 3'b011);
    run_literal("carry_sticky", 1'b0, 8'd10,  25'h1000003, 3'b000, 8'd11,  23'd2, 3'b001);

    // back-to-back beats with a three-cycle downstream stall
    @(posedge clk);
    #1;
    out_before = n_out;
    fork
      begin
        drive_beat(1'b0, 8'd127, 25'h1000000, 3'b000);
        drive_beat(1'b1, 8'd60,  25'h0C00000, 3'b110);
        drive_beat(1'b0, 8'd40,  25'h0000F00, 3'b001);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk);
          #1 seen = out_valid;
        end
        chk("stall_first_out", 64'(seen), 64'(1));
        out_ready = 1'b0;
        held = {out_sign, out_exp, out_frac, out_flags};
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_data", 64'({out_sign, out_exp, out_frac, out_flags}), 64'(held));
          chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 64'(n_out - out_before), 64'(3));

    // randomized traffic with random backpressure
    @(posedge clk);
    #1;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          case ($urandom_range(0, 5))
            0: mt = {1'b1, 24'($urandom)};
            1, 2: mt = {2'b01, 23'($urandom)};
            3: mt = {1'b0, 24'($urandom) >> $urandom_range(1, 24)};
            4: mt = 25'd0;
            default: mt = 25'($urandom);
          endcase
          case ($urandom_range(0, 3))
            0: ex = 8'd254;
            1: ex = 8'($urandom_range(0, 30));
            default: ex = 8'($urandom_range(0, 254));
          endcase
          drive_beat(1'($urandom), ex, mt, 3'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // asynchronous reset with two beats in flight
    @(posedge clk);
    #1;
    drive_beat(1'b0, 8'd127, 25'h0900000, 3'b000);
    drive_beat(1'b1, 8'd120, 25'h1400000, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_data", 64'({out_sign, out_exp, out_frac, out_flags}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", 64'(out_valid), 64'(0));
    run_literal("post_reset", 1'b1, 8'd127, 25'h1000000, 3'b000, 8'd128, 23'd0, 3'b000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_add_normalize_round.md
Name: fp_add_normalize_round

Overview:
- Post-add stage of the 32-bit floating-point adder. Consumes the raw 25-bit mantissa sum (carry + hidden + 23 fraction bits), the guard/round/sticky bits, the sign and the pre-normalisation exponent.
- Normalises the sum: right-shifts by 1 on carry-out, or left-shifts by the leading-zero count through barrelLeft.
- Rounds to nearest-even, then packs the IEEE-754 sign/exponent/fraction.
- Two-stage pipeline with a valid/ready handshake; its output feeds the adder result register.

Parameters:
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width; the mantissa sum is FRAC_W+2 bits.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- in_sign  input  1  result sign
- in_exp  input  8  exponent before normalisation (biased)
- in_mant  input  25  [24] carry, [23] hidden, [22:0] fraction
- in_grs  input  3  guard, round, sticky from alignment
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sign  output  1  result sign
- out_exp  output  8  biased result exponent
- out_frac  output  23  result fraction
- out_flags  output  3  {overflow, underflow, inexact}

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all pipeline valid bits clear, so out_valid=0; every data output register is 0.
- Pipeline enable: en = ~out_valid | out_ready, which makes in_ready = en. Both stages advance only when en=1. A beat transfers on in_valid & in_ready. Latency is exactly 2 cycles when there is no stall.
- Stall: while out_valid=1 and out_ready=0, every register holds and out_* stays stable. No beat is lost or duplicated.
- Stage 1 (registered): classify the beat and compute the leading-zero count lz (0..24) of in_mant[23:0] via lzc24.
  - CARRY: in_mant[24]=1.
  - ZERO: in_mant=0 and in_grs=0.
  - UFLOW: not CARRY, not ZERO, and in_exp <= lz. This includes in_mant[23:0]=0 with nonzero grs.
  - NORM: all other cases.
- Stage 2, CARRY:
  - m = in_mant[24:1] and e = in_exp+1.
  - G = mant[0], R = g, S = r|s.
- Stage 2, NORM:
  - {m, G, R} = left shift of {mant[23:0], g, r} by lz, zero-filled. The shift uses barrelLeft (25-bit) on {mant[23:0], g} with r shifted in one position.
  - S = s and e = in_exp - lz.
- Rounding: round_up = G & (R | S | m[0]). m' = m + round_up, 25 bits wide. If m'[24]=1, then e = e+1 and m' = m'>>1. inexact = G|R|S.
- Overflow: e >= 255 after either increment gives out_exp=255, out_frac=0 (infinity) and flags=100 plus inexact.
- ZERO: out_exp=0, out_frac=0, flags=000. out_sign passes through.
- UFLOW: flush to zero, out_exp=0, out_frac=0, flags=010 plus inexact if any nonzero bit was dropped.
- Input exponent 255 (inf/NaN) is not handled here; the upstream stage bypasses it.
- Simultaneous transfers: an input beat and an output handshake in the same cycle both complete.
- Reset mid-operation: in-flight beats are discarded and outputs return to 0 asynchronously.

Decomposition:
- Shared package fp_add_pkg holds EXP_W, FRAC_W, MANT_W=25, EXP_MAX=255, the flag bit indices and the class encoding {ZERO, CARRY, NORM, UFLOW}.
- One sub-module, lzc24: a combinational 24-bit leading-zero counter with a 5-bit output, returning 24 for all zeros.
- Reuse barrelLeft for the left shift; no new shifter.

Test Plan:
- 1.0+1.0: exp=127, mant=0x1000000, grs=000 -> after 2 cycles out_exp=128, frac=0, flags=000.
- Cancellation: exp=130, mant=0x0000001, grs=000 -> lz=23, out_exp=107, frac=0, flags=000.
- Round-up carry: exp=127, mant=0x0FFFFFF, grs=100 -> out_exp=128, frac=0, flags=001. Tie-to-even: exp=127, mant=0x0800000, grs=100 -> frac=0, flags=001.
- Overflow: exp=254, mant=0x1000000 -> out_exp=255, frac=0, flags=100. Underflow: exp=5, mant=0x0000100 -> out=0, flags=010.
- Back-to-back with stall: three beats on consecutive cycles, out_ready=0 for 3 cycles after the first result.
  - out_valid stays 1 with stable data and in_ready=0 during the stall.
  - All three results then emerge in order with no loss.
- Async reset asserted with 2 beats in flight -> out_valid=0 immediately. After release, the next beat produces the correct result 2 cycles later.
